// File: rtl/rs_issue_queue_pkg.sv
// Shared types and default sizing for the reservation-station issue queue.
// The packet and entry layouts are the contract between dispatch, the RS and the FU.
package rs_issue_queue_pkg;

  localparam int RS_ENTRIES = 4;
  localparam int NUM_FUS    = 4;
  localparam int NUM_PREGS  = 64;
  localparam int PREG_W     = $clog2(NUM_PREGS);

  typedef struct packed {
    logic              instr_valid;
    logic [31:0]       pc;
    logic [7:0]        opcode;
    logic [PREG_W-1:0] dst_preg;
    logic [PREG_W-1:0] src1_preg;
    logic [PREG_W-1:0] src2_preg;
  } disp_packet_t;

  typedef struct packed {
    disp_packet_t pkt;
    logic         src1_rdy;
    logic         src2_rdy;
    logic         valid;
  } rs_entry_t;

endpackage

// File: rtl/rs_issue_queue_if.sv
// Dispatch, wakeup, issue and flush signals between the pipeline and the RS.
// master = pipeline side driving dispatch/wakeup/issue_ready; slave = the RS.
interface rs_issue_queue_if #(
  parameter int DEPTH      = rs_issue_queue_pkg::RS_ENTRIES,
  parameter int NUM_WAKEUP = rs_issue_queue_pkg::NUM_FUS,
  parameter int PREG_W     = rs_issue_queue_pkg::PREG_W
);
  import rs_issue_queue_pkg::*;

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic                                 disp_valid;
  logic                                 disp_ready;
  disp_packet_t                         disp_pkt;
  logic                                 disp_src1_rdy;
  logic                                 disp_src2_rdy;
  logic [NUM_WAKEUP-1:0]                wk_valid;
  logic [NUM_WAKEUP-1:0][PREG_W-1:0]    wk_preg;
  logic                                 issue_valid;
  logic                                 issue_ready;
  disp_packet_t                         issue_pkt;
  logic                                 flush;
  logic [OCC_W-1:0]                     occupancy;

  modport master (
    output disp_valid, disp_pkt, disp_src1_rdy, disp_src2_rdy,
    output wk_valid, wk_preg, issue_ready, flush,
    input  disp_ready, issue_valid, issue_pkt, occupancy
  );

  modport slave (
    input  disp_valid, disp_pkt, disp_src1_rdy, disp_src2_rdy,
    input  wk_valid, wk_preg, issue_ready, flush,
    output disp_ready, issue_valid, issue_pkt, occupancy
  );

endinterface

// File: rtl/rs_issue_queue_age_select.sv
// Age matrix plus oldest-request one-hot select for the RS entries.
// age_q[i][j]=1 means entry i is older than entry j; only live entries carry bits.
module rs_age_select #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DEPTH-1:0] req_i,
  input  logic [DEPTH-1:0] alloc_i,
  input  logic [DEPTH-1:0] free_i,
  input  logic             flush_i,
  output logic [DEPTH-1:0] grant_o
);

  logic [DEPTH-1:0][DEPTH-1:0] age_q, age_d;
  logic [DEPTH-1:0]            live_q, live_d;

  always_comb begin
    age_d  = age_q;
    live_d = (live_q & ~free_i) | alloc_i;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (free_i[i] || free_i[j] || alloc_i[i]) begin
          age_d[i][j] = 1'b0;
        end
        // A new entry is younger than every entry that survives this edge.
        if (alloc_i[j] && (i != j) && live_q[i] && !free_i[i]) begin
          age_d[i][j] = 1'b1;
        end
      end
    end
    if (flush_i) begin
      age_d  = '0;
      live_d = '0;
    end
  end

  always_comb begin
    grant_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      grant_o[i] = req_i[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (req_i[j] && age_q[j][i]) begin
          grant_o[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age_q  <= '0;
      live_q <= '0;
    end else begin
      age_q  <= age_d;
      live_q <= live_d;
    end
  end

endmodule

// File: rtl/rs_issue_queue.sv
// Reservation station: holds dispatched ops until both sources are ready,
// snoops wakeup broadcasts and issues the oldest ready entry to the FU.
module rs_issue_queue #(
  parameter int DEPTH      = rs_issue_queue_pkg::RS_ENTRIES,
  parameter int NUM_WAKEUP = rs_issue_queue_pkg::NUM_FUS,
  parameter int PREG_W     = rs_issue_queue_pkg::PREG_W
) (
  input  logic             clk,
  input  logic             rst,
  rs_issue_queue_if.slave  rs
);
  import rs_issue_queue_pkg::*;

  localparam int OCC_W = $clog2(DEPTH + 1);

  rs_entry_t         ent_q [DEPTH];
  rs_entry_t         ent_d [DEPTH];
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              disp_ready_q, disp_ready_d;

  logic [DEPTH-1:0]  req_vec, alloc_oh, alloc_gated, free_oh, grant_oh;
  logic              disp_fire, issue_fire, issue_valid, found_free;
  logic              disp_hit1, disp_hit2;
  disp_packet_t      sel_pkt, issue_pkt;

  function automatic logic tag_hit(
    input logic [PREG_W-1:0]                  tag,
    input logic [NUM_WAKEUP-1:0]              vld,
    input logic [NUM_WAKEUP-1:0][PREG_W-1:0]  tags
  );
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_WAKEUP; k++) begin
      if (vld[k] && (tags[k] == tag)) begin
        hit = 1'b1;
      end
    end
    return hit;
  endfunction

  always_comb begin
    req_vec    = '0;
    alloc_oh   = '0;
    found_free = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      req_vec[i] = ent_q[i].valid && ent_q[i].src1_rdy && ent_q[i].src2_rdy;
      if (!ent_q[i].valid && !found_free) begin
        alloc_oh[i] = 1'b1;
        found_free  = 1'b1;
      end
    end
  end

  // disp_ready_q already implies a free slot exists, so alloc_oh is non-zero on fire.
  assign disp_fire   = rs.disp_valid && disp_ready_q && !rs.flush;
  assign issue_valid = (|req_vec) && !rs.flush;
  assign issue_fire  = issue_valid && rs.issue_ready;
  assign alloc_gated = disp_fire  ? alloc_oh : '0;
  assign free_oh     = issue_fire ? grant_oh : '0;

  rs_age_select #(.DEPTH(DEPTH)) u_age_select (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req_vec),
    .alloc_i (alloc_gated),
    .free_i  (free_oh),
    .flush_i (rs.flush),
    .grant_o (grant_oh)
  );

  always_comb begin
    sel_pkt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant_oh[i]) begin
        sel_pkt = sel_pkt | ent_q[i].pkt;
      end
    end
    issue_pkt = '0;
    if (issue_valid) begin
      issue_pkt             = sel_pkt;
      issue_pkt.instr_valid = 1'b1;
    end
  end

  assign disp_hit1 = tag_hit(rs.disp_pkt.src1_preg, rs.wk_valid, rs.wk_preg);
  assign disp_hit2 = tag_hit(rs.disp_pkt.src2_preg, rs.wk_valid, rs.wk_preg);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].valid) begin
        ent_d[i].src1_rdy = ent_q[i].src1_rdy |
                            tag_hit(ent_q[i].pkt.src1_preg, rs.wk_valid, rs.wk_preg);
        ent_d[i].src2_rdy = ent_q[i].src2_rdy |
                            tag_hit(ent_q[i].pkt.src2_preg, rs.wk_valid, rs.wk_preg);
      end
      if (free_oh[i]) begin
        ent_d[i] = '0;
      end
      if (alloc_gated[i]) begin
        ent_d[i].pkt      = rs.disp_pkt;
        ent_d[i].src1_rdy = rs.disp_src1_rdy | disp_hit1;
        ent_d[i].src2_rdy = rs.disp_src2_rdy | disp_hit2;
        ent_d[i].valid    = 1'b1;
      end
      if (rs.flush) begin
        ent_d[i] = '0;
      end
    end
  end

  always_comb begin
    occ_d = occ_q;
    if (rs.flush) begin
      occ_d = '0;
    end else if (disp_fire && !issue_fire) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!disp_fire && issue_fire) begin
      occ_d = occ_q - OCC_W'(1);
    end
    // Registered from the post-edge count, so a slot freed by issue is offered next cycle.
    disp_ready_d = (occ_d < OCC_W'(DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      occ_q        <= '0;
      disp_ready_q <= 1'b1;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      occ_q        <= occ_d;
      disp_ready_q <= disp_ready_d;
    end
  end

  assign rs.disp_ready  = disp_ready_q;
  assign rs.issue_valid = issue_valid;
  assign rs.issue_pkt   = issue_pkt;
  assign rs.occupancy   = occ_q;

endmodule

// File: tb/tb_rs_issue_queue.sv
// Self-checking bench for rs_issue_queue: directed vector table, hand-written
// corner sequences, then random traffic against an age-ordered queue model.
module tb_rs_issue_queue;
  import rs_issue_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int NW    = 4;
  localparam int PW    = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rs_issue_queue_if #(.DEPTH(DEPTH), .NUM_WAKEUP(NW), .PREG_W(PW)) rif ();

  rs_issue_queue #(.DEPTH(DEPTH), .NUM_WAKEUP(NW), .PREG_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .rs  (rif)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    rif.disp_valid    = 1'b0;
    rif.disp_pkt      = '0;
    rif.disp_src1_rdy = 1'b0;
    rif.disp_src2_rdy = 1'b0;
    rif.wk_valid      = '0;
    rif.wk_preg       = '0;
    rif.issue_ready   = 1'b0;
    rif.flush         = 1'b0;
  endtask

  task automatic set_disp(input logic [31:0] pc, input logic [5:0] s1, input logic [5:0] s2,
                          input logic r1, input logic r2);
    rif.disp_valid            = 1'b1;
    rif.disp_pkt.instr_valid  = 1'b1;
    rif.disp_pkt.pc           = pc;
    rif.disp_pkt.opcode       = pc[7:0] ^ 8'h5a;
    rif.disp_pkt.dst_preg     = pc[5:0];
    rif.disp_pkt.src1_preg    = s1;
    rif.disp_pkt.src2_preg    = s2;
    rif.disp_src1_rdy         = r1;
    rif.disp_src2_rdy         = r2;
  endtask

  typedef struct {
    logic        dv;
    logic [31:0] pc;
    logic [5:0]  s1, s2;
    logic        r1, r2;
    logic [3:0]  wkv;
    logic [5:0]  wkt;
    logic        ir, fl;
    logic        e_iv;
    logic [31:0] e_pc;
    logic [2:0]  e_occ;
    logic        e_dr;
  } vec_t;

  vec_t tbl [13];

  typedef struct {
    disp_packet_t p;
    bit           r1, r2;
  } mentry_t;

  mentry_t mq[$];

  function automatic bit wk_hit(input logic [5:0] t);
    for (int k = 0; k < NW; k++) begin
      if (rif.wk_valid[k] && rif.wk_preg[k] == t) return 1'b1;
    end
    return 1'b0;
  endfunction

  initial begin
    rst = 1'b1;
    idle();
    #1;
    chk("rst_occ", rif.occupancy, 0);
    chk("rst_dr", rif.disp_ready, 1);
    chk("rst_iv", rif.issue_valid, 0);
    chk("rst_pkt", rif.issue_pkt, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    //          dv  pc         s1  s2  r1 r2 wkv     wkt ir fl | iv pc        occ dr
    tbl[0]  = '{1, 32'h100,  1,  2,  1, 1, 4'h0,   0,  0, 0,   0, 32'h0,   0,  1};
    tbl[1]  = '{0, 32'h0,    0,  0,  0, 0, 4'h0,   0,  1, 0,   1, 32'h100, 1,  1};
    tbl[2]  = '{0, 32'h0,    0,  0,  0, 0, 4'h0,   0,  0, 0,   0, 32'h0,   0,  1};
    tbl[3]  = '{1, 32'h200,  5,  3,  0, 1, 4'h0,   0,  0, 0,   0, 32'h0,   0,  1};
    tbl[4]  = '{1, 32'h300,  1,  2,  1, 1, 4'h0,   0,  0, 0,   0, 32'h0,   1,  1};
    tbl[5]  = '{0, 32'h0,    0,  0,  0, 0, 4'h1,   5,  1, 0,   1, 32'h300, 2,  1};
    tbl[6]  = '{1, 32'h400,  6,  7,  1, 1, 4'h0,   0,  0, 0,   1, 32'h200, 1,  1};
    tbl[7]  = '{0, 32'h0,    0,  0,  0, 0, 4'h0,   0,  1, 0,   1, 32'h200, 2,  1};
    tbl[8]  = '{0, 32'h0,    0,  0,  0, 0, 4'h0,   0,  1, 0,   1, 32'h400, 1,  1};
    tbl[9]  = '{0, 32'h0,    0,  0,  0, 0, 4'h0,   0,  0, 0,   0, 32'h0,   0,  1};
    tbl[10] = '{1, 32'h500,  4,  9,  1, 0, 4'h4,   9,  0, 0,   0, 32'h0,   0,  1};
    tbl[11] = '{0, 32'h0,    0,  0,  0, 0, 4'h0,   0,  1, 0,   1, 32'h500, 1,  1};
    tbl[12] = '{0, 32'h0,    0,  0,  0, 0, 4'h0,   0,  0, 0,   0, 32'h0,   0,  1};

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      idle();
      if (tbl[i].dv) set_disp(tbl[i].pc, tbl[i].s1, tbl[i].s2, tbl[i].r1, tbl[i].r2);
      rif.wk_valid = tbl[i].wkv;
      for (int k = 0; k < NW; k++) rif.wk_preg[k] = tbl[i].wkt;
      rif.issue_ready = tbl[i].ir;
      rif.flush       = tbl[i].fl;
      #1;
      chk($sformatf("vec%0d_iv", i), rif.issue_valid, tbl[i].e_iv);
      if (tbl[i].e_iv) chk($sformatf("vec%0d_pc", i), rif.issue_pkt.pc, tbl[i].e_pc);
      else             chk($sformatf("vec%0d_pkt0", i), rif.issue_pkt, 0);
      chk($sformatf("vec%0d_occ", i), rif.occupancy, tbl[i].e_occ);
      chk($sformatf("vec%0d_dr", i), rif.disp_ready, tbl[i].e_dr);
    end

    // Fill to DEPTH with entries blocked on tag 10.
    for (int n = 0; n < DEPTH; n++) begin
      @(negedge clk);
      idle();
      set_disp(32'h1000 + n, 10, 11, 0, 1);
      #1;
      chk("fill_dr", rif.disp_ready, 1);
    end
    @(negedge clk);
    idle();
    set_disp(32'h2000, 1, 2, 1, 1);
    #1;
    chk("full_dr", rif.disp_ready, 0);
    chk("full_occ", rif.occupancy, 4);
    chk("full_iv", rif.issue_valid, 0);
    @(negedge clk);
    idle();
    rif.wk_valid[0] = 1'b1;
    rif.wk_preg[0]  = 6'd10;
    #1;
    chk("ignored_occ", rif.occupancy, 4);
    chk("ignored_dr", rif.disp_ready, 0);
    @(negedge clk);
    idle();
    rif.issue_ready = 1'b1;
    set_disp(32'h3000, 1, 2, 1, 1);
    #1;
    chk("xfer_iv", rif.issue_valid, 1);
    chk("xfer_pc", rif.issue_pkt.pc, 32'h1000);
    chk("xfer_dr_same", rif.disp_ready, 0);
    @(negedge clk);
    idle();
    set_disp(32'h1004, 1, 2, 1, 1);
    #1;
    chk("after_dr", rif.disp_ready, 1);
    chk("after_occ", rif.occupancy, 3);
    chk("after_pc", rif.issue_pkt.pc, 32'h1001);

    // Flush on a full RS while dispatch and issue_ready are both asserted.
    @(negedge clk);
    idle();
    set_disp(32'h5000, 1, 2, 1, 1);
    rif.issue_ready = 1'b1;
    rif.flush       = 1'b1;
    #1;
    chk("flush_occ_pre", rif.occupancy, 4);
    chk("flush_iv_gated", rif.issue_valid, 0);
    chk("flush_pkt_zero", rif.issue_pkt, 0);
    @(negedge clk);
    idle();
    #1;
    chk("flush_occ", rif.occupancy, 0);
    chk("flush_iv", rif.issue_valid, 0);
    chk("flush_dr", rif.disp_ready, 1);

    // Backpressure for three cycles, then async reset mid-cycle.
    @(negedge clk);
    idle();
    set_disp(32'h6000, 1, 2, 1, 1);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      idle();
      #1;
      chk("hold_iv", rif.issue_valid, 1);
      chk("hold_pc", rif.issue_pkt.pc, 32'h6000);
      chk("hold_occ", rif.occupancy, 1);
    end
    @(negedge clk);
    idle();
    rif.issue_ready = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    chk("arst_occ", rif.occupancy, 0);
    chk("arst_iv", rif.issue_valid, 0);
    chk("arst_pkt", rif.issue_pkt, 0);
    chk("arst_dr", rif.disp_ready, 1);
    @(negedge clk);
    idle();
    @(negedge clk);
    rst = 1'b0;

    // Random traffic against an oldest-first queue model.
    mq.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int           sel;
      bit           e_iv;
      disp_packet_t e_pkt;
      disp_packet_t np;
      bit           dv, ir, fl;
      @(negedge clk);
      idle();
      dv = ($urandom_range(0, 99) < 60);
      ir = ($urandom_range(0, 99) < 50);
      fl = ($urandom_range(0, 99) < 3);
      if (dv) set_disp($urandom, 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
                       $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0);
      rif.wk_valid = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      for (int k = 0; k < NW; k++) rif.wk_preg[k] = 6'($urandom_range(0, 7));
      rif.issue_ready = ir;
      rif.flush       = fl;

      sel = -1;
      for (int q = 0; q < mq.size(); q++) begin
        if (sel < 0 && mq[q].r1 && mq[q].r2) sel = q;
      end
      e_iv  = (sel >= 0) && !fl;
      e_pkt = '0;
      if (e_iv) begin
        e_pkt             = mq[sel].p;
        e_pkt.instr_valid = 1'b1;
      end
      #1;
      chk("rnd_iv", rif.issue_valid, e_iv);
      chk("rnd_pkt", rif.issue_pkt, e_pkt);
      chk("rnd_occ", rif.occupancy, mq.size());
      chk("rnd_dr", rif.disp_ready, mq.size() < DEPTH);

      if (fl) begin
        mq.delete();
      end else begin
        bit dok;
        dok = dv && (mq.size() < DEPTH);
        np  = rif.disp_pkt;
        if (e_iv && ir) mq.delete(sel);
        foreach (mq[q]) begin
          mq[q].r1 |= wk_hit(mq[q].p.src1_preg);
          mq[q].r2 |= wk_hit(mq[q].p.src2_preg);
        end
        if (dok) begin
          mq.push_back('{p: np,
                         r1: rif.disp_src1_rdy | wk_hit(np.src1_preg),
                         r2: rif.disp_src2_rdy | wk_hit(np.src2_preg)});
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
